decode_queue: RTL

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/pipeline_pkg.sv | 57 +++++
 rtl/decode_queue.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: decoded control bundle and encodings shared by decode and execute
package pipeline_pkg;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [2:0] MDU_NONE = 3'd0;
  localparam logic [2:0] MDU_MUL  = 3'd1;
  localparam logic [2:0] MDU_DIV  = 3'd2;
  localparam logic [2:0] MDU_REM  = 3'd3;
  localparam logic [2:0] MDU_REMU = 3'd4;
  localparam logic [2:0] MDU_MULW = 3'd5;
  localparam logic [3:0] OP_NONE   = 4'd0;
  localparam logic [3:0] OP_ALU    = 4'd1;
  localparam logic [3:0] OP_ALUW   = 4'd2;
  localparam logic [3:0] OP_LOAD   = 4'd3;
  localparam logic [3:0] OP_STORE  = 4'd4;
  localparam logic [3:0] OP_BRANCH = 4'd5;
  localparam logic [3:0] OP_LUI    = 4'd6;
  localparam logic [3:0] OP_AUIPC  = 4'd7;
  localparam logic [3:0] OP_JAL    = 4'd8;
  localparam logic [3:0] OP_JALR   = 4'd9;
  localparam logic [3:0] OP_CSR    = 4'd10;
  localparam logic [3:0] OP_SYS    = 4'd11;
  typedef struct packed {
    logic       reg_write;
    logic       is_imm;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       jump;
    logic       csr;
    logic       exception;
    logic       mret;
    logic [3:0] aluop;
    logic [2:0] mduop;
    logic [3:0] op;
  } control_t;
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_of = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_of = ALU_SLL;
      3'b010:  alu_of = ALU_SLT;
      3'b011:  alu_of = ALU_SLTU;
      3'b100:  alu_of = ALU_XOR;
      3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/decode_queue.sv
// decode_queue: decodes fetched RV64IM/Zicsr words and buffers them in a strict FIFO
module decode_queue import pipeline_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [31:0]                in_instr,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_instr,
  output logic [XLEN-1:0]            out_imm,
  output control_t                   out_ctl,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [31:0]     instr_q [DEPTH];
  logic [XLEN-1:0] imm_q [DEPTH];
  control_t        ctl_q [DEPTH];
  logic            ill_q [DEPTH];
  logic [PW-1:0]   head, tail;
  logic            push, pop;
  control_t        c, d_ctl;
  logic [XLEN-1:0] imm, d_imm;
  logic            ill;
  logic [6:0]      op7, f7;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_c;
  assign op7 = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];
  assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){in_instr[31]}}, in_instr[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign imm_c = {{(XLEN-5){1'b0}}, in_instr[19:15]};
  always_comb begin
    c = '0;
    imm = '0;
    ill = 1'b0;
    case (op7)
      7'b0110011: begin
        c.reg_write = 1'b1;
        c.op = OP_ALU;
        if (f7 == 7'b0000001) begin
          c.mduop = f3 == 3'b000 ? MDU_MUL : f3 == 3'b100 ? MDU_DIV : f3 == 3'b110 ? MDU_REM : MDU_REMU;
          ill = !(f3 == 3'b000 || f3 == 3'b100 || f3 == 3'b110 || f3 == 3'b111);
        end else begin
          c.aluop = alu_of(f3, f7[5]);
          ill = !(f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
        end
      end
      7'b0111011: begin
        c.reg_write = 1'b1;
        c.op = OP_ALUW;
        if (f7 == 7'b0000001) begin
          c.mduop = MDU_MULW;
          ill = f3 != 3'b000;
        end else begin
          c.aluop = alu_of(f3, f7[5]);
          ill = !(((f7 == 7'b0 || f7 == 7'b0100000) && (f3 == 3'b000 || f3 == 3'b101)) || (f7 == 7'b0 && f3 == 3'b001));
        end
      end
      7'b0010011: begin
        c.reg_write = 1'b1;
        c.is_imm = 1'b1;
        c.op = OP_ALU;
        c.aluop = alu_of(f3, f3 == 3'b101 && in_instr[30]);
        imm = imm_i;
        ill = (f3 == 3'b001 && in_instr[31:26] != 6'b0) ||
              (f3 == 3'b101 && in_instr[31:26] != 6'b0 && in_instr[31:26] != 6'b010000);
      end
      7'b0011011: begin
        c.reg_write = 1'b1;
        c.is_imm = 1'b1;
        c.op = OP_ALUW;
        c.aluop = alu_of(f3, f3 == 3'b101 && in_instr[30]);
        imm = imm_i;
        ill = !(f3 == 3'b000 || (f3 == 3'b001 && f7 == 7'b0) || (f3 == 3'b101 && (f7 == 7'b0 || f7 == 7'b0100000)));
      end
      7'b0000011: begin
        c.reg_write = 1'b1;
        c.is_imm = 1'b1;
        c.mem_read = 1'b1;
        c.mem_to_reg = 1'b1;
        c.op = OP_LOAD;
        imm = imm_i;
        ill = f3 == 3'b111;
      end
      7'b0100011: begin
        c.is_imm = 1'b1;
        c.mem_write = 1'b1;
        c.op = OP_STORE;
        imm = imm_s;
        ill = f3[2];
      end
      7'b1100011: begin
        c.aluop = ALU_SUB;
        c.op = OP_BRANCH;
        imm = imm_b;
        ill = f3[2:1] == 2'b01;
      end
      7'b0110111, 7'b0010111: begin
        c.reg_write = 1'b1;
        c.is_imm = 1'b1;
        c.op = op7[5] ? OP_LUI : OP_AUIPC;
        imm = imm_u;
      end
      7'b1101111: begin
        c.reg_write = 1'b1;
        c.jump = 1'b1;
        c.op = OP_JAL;
        imm = imm_j;
      end
      7'b1100111: begin
        c.reg_write = 1'b1;
        c.is_imm = 1'b1;
        c.jump = 1'b1;
        c.op = OP_JALR;
        imm = imm_i;
        ill = f3 != 3'b000;
      end
      7'b1110011: begin
        imm = imm_c;
        if (f3 == 3'b000) begin
          c.op = OP_SYS;
          c.exception = in_instr == 32'h0000_0073;
          c.mret = in_instr == 32'h3020_0073;
          ill = !(c.exception || c.mret);
        end else begin
          c.reg_write = 1'b1;
          c.csr = 1'b1;
          c.is_imm = f3[2];
          c.op = OP_CSR;
          ill = f3 == 3'b100;
        end
      end
      default: ill = 1'b1;
    endcase
  end
  // illegal encodings carry no control or immediate so execute sees a clean bubble plus the flag
  assign d_ctl = ill ? '0 : c;
  assign d_imm = ill ? '0 : imm;
  assign in_ready  = count < CW'(DEPTH);
  assign out_valid = count != '0;
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;
  always_ff @(posedge clk)
    if (push) begin
      pc_q[tail]    <= in_pc;
      instr_q[tail] <= in_instr;
      imm_q[tail]   <= d_imm;
      ctl_q[tail]   <= d_ctl;
      ill_q[tail]   <= ill;
    end
  always_ff @(posedge clk)
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail + PW'(push);
      count <= count + CW'(push) - CW'(pop);
    end
  assign out_pc      = out_valid ? pc_q[head] : '0;
  assign out_instr   = out_valid ? instr_q[head] : '0;
  assign out_imm     = out_valid ? imm_q[head] : '0;
  assign out_ctl     = out_valid ? ctl_q[head] : '0;
  assign out_illegal = out_valid && ill_q[head];
endmodule
